// File: rtl/apb_slave_pkg.sv
// Shared types for the APB3 register-array completer.
// Holds the FSM state encoding and the registered response bundle.
package apb_slave_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_slv_state_e;

   localparam int ADDR_LSB = 2;

   typedef struct packed {
      logic ready;
      logic err;
   } apb_resp_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W register array, synchronous clear on reset.
// One synchronous write port, one combinational read port.
module apb_slave_regfile #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DEPTH-1:0][DATA_W-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer over a word array with fixed wait states and bad-address error.
// Define APB_SLAVE_MEM_PSLVERR_EN to drive pslverr; otherwise it is tied low.
module apb_slave_mem
   import apb_slave_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              psel,
   input  logic              penable,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = 4;

   apb_slv_state_e    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              write_q, write_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   apb_resp_t         resp_q, resp_d;

   logic [ADDR_W-ADDR_LSB-1:0] a_idx;
   logic [DATA_W-1:0]          rdata;
   logic                       setup;
   logic                       done;
   logic                       err_in;
   logic                       we;

   assign a_idx  = paddr[ADDR_W-1:ADDR_LSB];
   // Extra zero bit keeps the compare correct when DEPTH fills the index space
   assign err_in = (paddr[ADDR_LSB-1:0] != '0) ||
                   ({1'b0, a_idx} >= (ADDR_W-ADDR_LSB+1)'(DEPTH));
   assign setup  = (state_q == IDLE) && psel && !penable;
   assign done   = (state_q == ACCESS) && psel && penable && resp_q.ready;
   assign we     = done && write_q && !err_q;

   apb_slave_regfile #(
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk    (clk),
      .resetn (resetn),
      .we     (we),
      .waddr  (idx_q),
      .wdata  (pwdata),
      .raddr  (a_idx[IDX_W-1:0]),
      .rdata  (rdata)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         prdata_q <= '0;
         resp_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         write_q  <= write_d;
         err_q    <= err_d;
         prdata_q <= prdata_d;
         resp_q   <= resp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel || (penable && resp_q.ready)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      write_d  = write_q;
      err_d    = err_q;
      prdata_d = prdata_q;
      resp_d   = resp_q;
      if (setup) begin
         idx_d        = a_idx[IDX_W-1:0];
         write_d      = pwrite;
         err_d        = err_in;
         cnt_d        = CNT_W'(WAIT_STATES);
         resp_d.ready = (WAIT_STATES == 0);
         if (!pwrite) begin
            prdata_d = err_in ? '0 : rdata;
         end
      end else if (state_q == ACCESS) begin
         if (!psel || done) begin
            cnt_d  = '0;
            resp_d = '0;
         end else if (cnt_q != '0) begin
            cnt_d        = cnt_q - 1'b1;
            resp_d.ready = (cnt_q == CNT_W'(1));
         end
      end
`ifdef APB_SLAVE_MEM_PSLVERR_EN
      resp_d.err = resp_d.ready && err_d;
`else
      resp_d.err = 1'b0;
`endif
   end

   assign prdata  = prdata_q;
   assign pready  = resp_q.ready;
   assign pslverr = resp_q.err;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: one instance with 0 and one with 2 wait states.
// The driver queues expected responses; a negedge monitor checks each pready.
module tb_apb_slave_mem;

`ifdef APB_SLAVE_MEM_PSLVERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;

   logic [31:0] prdata0, prdata2;
   logic        pready0, pready2;
   logic        pslverr0, pslverr2;

   logic [31:0] mon_prdata;
   logic        mon_pready;
   logic        mon_pslverr;

   typedef struct {
      logic [31:0] data;
      logic        chk_data;
      logic        err;
      int          lat;
      int          t0;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   sel = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   apb_slave_mem #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)
   ) u_dut0 (
      .clk(clk), .resetn(resetn), .psel(psel), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
   );

   apb_slave_mem #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(2)
   ) u_dut2 (
      .clk(clk), .resetn(resetn), .psel(psel), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
   );

   assign mon_prdata  = (sel != 0) ? prdata2  : prdata0;
   assign mon_pready  = (sel != 0) ? pready2  : pready0;
   assign mon_pslverr = (sel != 0) ? pslverr2 : pslverr0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resetn && mon_pready) begin
         if (q.size() == 0) begin
            check("unexpected_pready", 32'd1, 32'd0);
         end else begin
            e_mon = q.pop_front();
            check("latency", 32'(cyc - e_mon.t0), 32'(e_mon.lat));
            if (e_mon.chk_data) check("prdata", mon_prdata, e_mon.data);
            check("pslverr", {31'd0, mon_pslverr}, {31'd0, e_mon.err});
         end
      end
   end

   task automatic xfer(input logic [31:0] a, input logic wr,
                       input logic [31:0] wd, input logic [31:0] ed,
                       input logic cd, input logic eerr);
      exp_t e;
      int   n;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0;
      paddr = a; pwrite = wr; pwdata = wd;
      e.data = ed; e.chk_data = cd; e.err = eerr & ERR_EN;
      e.lat = 1 + ((sel != 0) ? 2 : 0);
      e.t0 = cyc;
      q.push_back(e);
      @(negedge clk);
      penable = 1'b1;
      n = 0;
      while (!mon_pready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!mon_pready) begin
         check("xfer_timeout", 32'd0, 32'd1);
         q.delete();
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      q.delete();
   endtask

   task automatic count_pready(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (mon_pready) cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      sel = 0;
      repeat (2) @(negedge clk);
      check("rst_prdata0", prdata0, 32'h0);
      check("rst_pready0", {31'd0, pready0}, 32'h0);
      check("rst_pslverr0", {31'd0, pslverr0}, 32'h0);
      check("rst_prdata2", prdata2, 32'h0);
      resetn = 1'b1;

      xfer(32'h08, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
      go_idle();
      xfer(32'h08, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
      go_idle();

      xfer(32'h00, 1'b1, 32'h11, 32'hDEADBEEF, 1'b1, 1'b0);
      xfer(32'h04, 1'b1, 32'h22, 32'hDEADBEEF, 1'b1, 1'b0);
      xfer(32'h00, 1'b0, 32'h0, 32'h11, 1'b1, 1'b0);
      xfer(32'h04, 1'b0, 32'h0, 32'h22, 1'b1, 1'b0);
      go_idle();

      xfer(32'h40, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      go_idle();
      xfer(32'h06, 1'b1, 32'h1234, 32'h0, 1'b1, 1'b1);
      go_idle();
      xfer(32'h04, 1'b0, 32'h0, 32'h22, 1'b1, 1'b0);
      go_idle();

      @(negedge clk);
      psel = 1'b1; penable = 1'b1; paddr = 32'h08; pwrite = 1'b0;
      count_pready(4, c);
      check("orphan_penable", 32'(c), 32'd0);
      go_idle();
      xfer(32'h08, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
      go_idle();

      sel = 1;
      do_reset();
      xfer(32'h04, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      go_idle();

      @(negedge clk);
      psel = 1'b1; penable = 1'b0;
      paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h55;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      count_pready(6, c);
      check("abort_no_pready", 32'(c), 32'd0);
      xfer(32'h0C, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      go_idle();

      xfer(32'h08, 1'b1, 32'h77, 32'h0, 1'b1, 1'b0);
      xfer(32'h08, 1'b0, 32'h0, 32'h77, 1'b1, 1'b0);
      go_idle();

      @(negedge clk);
      psel = 1'b1; penable = 1'b0;
      paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h99;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1; psel = 1'b0; penable = 1'b0;
      check("midrst_prdata", prdata2, 32'h0);
      check("midrst_pready", {31'd0, pready2}, 32'h0);
      check("midrst_pslverr", {31'd0, pslverr2}, 32'h0);

      for (int i = 0; i < 16; i++) begin
         xfer(32'(i * 4), 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      go_idle();
      repeat (3) @(negedge clk);

      check("queue_empty", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
